// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: steps one digit slot at a time,
// swaps in a newly offered value only at a frame boundary.
module seg_scan_ctrl #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_valid,
    input  logic [4*NDIG-1:0] upd_value,
    output logic              upd_ready,
    input  logic              lz_en,
    output logic [3:0]        code,
    output logic [NDIG-1:0]   an,
    output logic              frame_tick
);

    localparam int DIVW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(REFRESH_DIV - 1);
    localparam logic [DIVW-1:0] GUARD_END = DIVW'(GUARD);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NDIG - 1);

    logic [DIVW-1:0]   div;
    logic [IDXW-1:0]   idx;
    logic [4*NDIG-1:0] pend;
    logic              pend_full;
    logic [4*NDIG-1:0] shadow;
    logic              wrap;
    logic              wrap_d;
    logic [3:0]        cur_nib;
    logic              cur_supp;
    logic              zero_above;
    logic [NDIG-1:0]   an_next;

    assign upd_ready = !pend_full;
    assign wrap      = (div == DIV_LAST) && (idx == IDX_LAST);

    // Walk from the top digit down so zero_above tells whether every nibble
    // from the top through digit i is zero.
    always_comb begin
        cur_nib    = 4'd0;
        cur_supp   = 1'b0;
        zero_above = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_above = zero_above && (shadow[4*i +: 4] == 4'd0);
            if (idx == IDXW'(i)) begin
                cur_nib  = shadow[4*i +: 4];
                cur_supp = lz_en && (i > 0) && zero_above;
            end
        end
    end

    always_comb begin
        an_next = '1;
        if (div >= GUARD_END && !cur_supp)
            an_next = ~({{(NDIG-1){1'b0}}, 1'b1} << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            idx        <= '0;
            pend       <= '0;
            pend_full  <= 1'b0;
            shadow     <= '0;
            wrap_d     <= 1'b0;
            code       <= 4'd0;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (div == DIV_LAST)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

            // A transfer cannot coincide with a consuming boundary: ready is low while pend is full.
            if (wrap && pend_full) begin
                shadow    <= pend;
                pend_full <= 1'b0;
            end else if (upd_valid && upd_ready) begin
                pend      <= upd_value;
                pend_full <= 1'b1;
            end

            // Outputs lag div/idx by one cycle, so the tick lands on the first slot-0 output cycle.
            wrap_d     <= wrap;
            frame_tick <= wrap_d;
            code       <= cur_nib;
            an         <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl, checked every cycle against a
// cycle-count based reference model of the scan and update rules.
module tb_seg_scan_ctrl;

    localparam int NDIG        = 4;
    localparam int REFRESH_DIV = 8;
    localparam int GUARD       = 2;
    localparam int FRAME       = NDIG * REFRESH_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_value = 16'h0;
    logic        upd_ready;
    logic        lz_en = 1'b0;
    logic [3:0]  code;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model: t counts cycles since the last reset edge.
    int          t = 0;
    logic [15:0] m_shadow = 16'h0;
    logic [15:0] m_pend = 16'h0;
    bit          m_pend_full = 1'b0;
    logic [3:0]  exp_code = 4'h0;
    logic [3:0]  exp_an = 4'hF;
    logic        exp_ft = 1'b0;
    bit          model_ok = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NDIG(NDIG), .REFRESH_DIV(REFRESH_DIV), .GUARD(GUARD)) dut (
        .clk(clk),
        .rst(rst),
        .upd_valid(upd_valid),
        .upd_value(upd_value),
        .upd_ready(upd_ready),
        .lz_en(lz_en),
        .code(code),
        .an(an),
        .frame_tick(frame_tick)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check the outputs of the previous edge, drive inputs, advance the model.
    task automatic applyStimulus(input logic r, input logic v, input logic [15:0] val, input logic lz);
        int  div;
        int  slot;
        bit  accept;
        bit  consume;
        @(negedge clk);
        cyc++;
        if (model_ok) begin
            checkOutput("an", 32'(an), 32'(exp_an));
            checkOutput("code", 32'(code), 32'(exp_code));
            checkOutput("frame_tick", 32'(frame_tick), 32'(exp_ft));
            checkOutput("upd_ready", 32'(upd_ready), 32'(!m_pend_full));
            checkOutput("an_single_low", 32'($countones(~an) <= 1), 32'd1);
        end
        rst       = r;
        upd_valid = v;
        upd_value = val;
        lz_en     = lz;
        if (r) begin
            t           = 0;
            m_shadow    = 16'h0;
            m_pend_full = 1'b0;
            exp_an      = 4'hF;
            exp_code    = 4'h0;
            exp_ft      = 1'b0;
            model_ok    = 1'b1;
        end else if (model_ok) begin
            div      = t % REFRESH_DIV;
            slot     = (t / REFRESH_DIV) % NDIG;
            exp_code = 4'((m_shadow >> (4 * slot)) & 16'hF);
            if (div < GUARD)
                exp_an = 4'hF;
            else if (lz && slot > 0 && (m_shadow >> (4 * slot)) == 16'h0)
                exp_an = 4'hF;
            else
                exp_an = ~(4'b0001 << slot);
            exp_ft  = (t % FRAME == 0) && (t > 0);
            accept  = v && !m_pend_full;
            consume = (t % FRAME == FRAME - 1) && m_pend_full;
            if (consume) begin
                m_shadow    = m_pend;
                m_pend_full = 1'b0;
            end
            if (accept) begin
                m_pend      = val;
                m_pend_full = 1'b1;
            end
            t++;
        end
    endtask

    task automatic idle(input int n, input logic lz);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 16'h0, lz);
    endtask

    initial begin
        logic [15:0] rval;
        logic [15:0] mask;
        logic        rv;
        logic        rlz;
        bit          holding;

        $display("[TB] starting seg_scan_ctrl bench");
        repeat (2) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Mid-frame update, visible only from the next slot 0
        idle(10, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h1A2F, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Back-pressure: 1111 held, then 2222 held while pend is full
        repeat (3) applyStimulus(1'b0, 1'b1, 16'h1111, 1'b0);
        for (int k = 0; k < 3 * FRAME; k++) applyStimulus(1'b0, 1'b1, 16'h2222, 1'b0);
        idle(FRAME, 1'b0);

        // Leading-zero suppression
        applyStimulus(1'b0, 1'b1, 16'h0030, 1'b1);
        idle(2 * FRAME, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(2 * FRAME, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0030, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Reset during slot 2 with a pending value
        for (int k = 0; k < FRAME && ((t % FRAME) / REFRESH_DIV) != 0; k++) idle(1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0);
        for (int k = 0; k < FRAME && ((t % FRAME) / REFRESH_DIV) != 2; k++) idle(1, 1'b0);
        checkOutput("pend_full_before_reset", 32'(upd_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Randomized traffic; the source holds its value until accepted
        holding = 1'b0;
        rval    = 16'h0;
        rlz     = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            rv = ($urandom_range(0, 3) == 0);
            if (!holding) begin
                case ($urandom_range(0, 4))
                    0: mask = 16'hFFFF;
                    1: mask = 16'h0FFF;
                    2: mask = 16'h00FF;
                    3: mask = 16'h000F;
                    default: mask = 16'h0000;
                endcase
                rval = 16'($urandom) & mask;
            end
            if ($urandom_range(0, 63) == 0) rlz = ~rlz;
            if ($urandom_range(0, 499) == 0) begin
                applyStimulus(1'b1, 1'b0, rval, rlz);
                holding = 1'b0;
            end else begin
                holding = rv && m_pend_full;
                applyStimulus(1'b0, rv, rval, rlz);
            end
        end
        idle(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
